// File: rtl/bus_responder_pkg.sv
// Shared types for the bus responder: access sizes, FSM states and the
// request fields captured when a request is accepted in IDLE.
package busResponderGroup;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } accessSize;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } responderState;

    typedef struct packed {
        accessSize   size;
        logic        signedLoad;
        logic [1:0]  lane;
        logic [31:0] writeData;
        logic        isWrite;
        logic        isError;
    } requestFields;

    localparam int WAIT_CNT_W = 4;

    // A request is rejected when both strobes are set, the size code is
    // illegal, or the address is not naturally aligned for the size.
    function automatic logic isRejected(input logic       rd,
                                        input logic       wr,
                                        input logic [1:0] sizeCode,
                                        input logic [1:0] lane);
        logic bad;
        case (sizeCode)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lane[0];
            2'd2:    bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

endpackage

// File: rtl/bus_responder_lane_aligner.sv
// Byte-lane steering between the CPU's right-justified data and the
// word-organised RAM: store replication/byte enables and load extraction.
module laneAligner
    import busResponderGroup::*;
(
    input  accessSize   i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_signedLoad,
    input  logic [31:0] i_storeData,
    input  logic [31:0] i_loadWord,
    output logic [31:0] o_storeData,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_loadData
);
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;

    assign w_loadByte = i_loadWord[{i_lane, 3'b000} +: 8];
    assign w_loadHalf = i_lane[1] ? i_loadWord[31:16] : i_loadWord[15:0];

    // Store side: replicate narrow data across the word, enable only the target lanes.
    always_comb begin
        o_storeData = i_storeData;
        o_byteEn    = 4'b1111;
        case (i_size)
            BYTE: begin
                o_storeData = {4{i_storeData[7:0]}};
                o_byteEn    = 4'b0001 << i_lane;
            end
            HALF: begin
                o_storeData = {2{i_storeData[15:0]}};
                o_byteEn    = i_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        o_loadData = i_loadWord;
        case (i_size)
            BYTE:    o_loadData = {{24{i_signedLoad & w_loadByte[7]}}, w_loadByte};
            HALF:    o_loadData = {{16{i_signedLoad & w_loadHalf[15]}}, w_loadHalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: request latch, wait-state counter and the
// IDLE/WAIT/ACCESS/RESPOND sequencer driving a synchronous word RAM.
module bus_responder
    import busResponderGroup::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  readReq,
    input  logic                  writeReq,
    input  logic [1:0]            size,
    input  logic                  signedLoad,
    input  logic [31:0]           writeData,
    output logic                  ready,
    output logic                  error,
    output logic [31:0]           readData,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memReadEn,
    output logic                  memWriteEn,
    output logic [3:0]            memByteEn,
    output logic [31:0]           memWriteData,
    input  logic [31:0]           memReadData
);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    responderState           r_state;
    responderState           w_nextState;
    requestFields            r_req;
    logic [ADDR_WIDTH-1:0]   r_wordAddr;
    logic [WAIT_CNT_W-1:0]   r_waitCnt;

    logic                    w_accept;
    logic                    w_reject;
    logic [31:0]             w_storeData;
    logic [31:0]             w_loadData;
    logic [3:0]              w_byteEn;
    logic                    w_unusedAddrBits;

    assign w_accept         = (r_state == ST_IDLE) && (readReq || writeReq);
    assign w_reject         = isRejected(readReq, writeReq, size, address[1:0]);
    // Address bits above the RAM's reach alias onto the same words.
    assign w_unusedAddrBits = ^address[31:ADDR_WIDTH+2];

    // Sequencer state register; reset returns to IDLE from anywhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // Capture the request in IDLE so the requester may drop its inputs afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req      <= '0;
            r_wordAddr <= '0;
        end else if (w_accept) begin
            r_req.size       <= accessSize'(size);
            r_req.signedLoad <= signedLoad;
            r_req.lane       <= address[1:0];
            r_req.writeData  <= writeData;
            r_req.isWrite    <= writeReq;
            r_req.isError    <= w_reject;
            r_wordAddr       <= address[ADDR_WIDTH+1:2];
        end
    end

    // Wait-state down-counter: loaded on acceptance, counts down while in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    r_waitCnt <= '0;
        else if (w_accept)             r_waitCnt <= WAIT_INIT;
        else if (r_state == ST_WAIT)   r_waitCnt <= r_waitCnt - 1'b1;
    end

    laneAligner u_laneAligner (
        .i_size       (r_req.size),
        .i_lane       (r_req.lane),
        .i_signedLoad (r_req.signedLoad),
        .i_storeData  (r_req.writeData),
        .i_loadWord   (memReadData),
        .o_storeData  (w_storeData),
        .o_byteEn     (w_byteEn),
        .o_loadData   (w_loadData)
    );

    // Next-state logic and output decode from the registered state.
    always_comb begin
        w_nextState  = r_state;
        ready        = 1'b0;
        error        = 1'b0;
        readData     = '0;
        memReadEn    = 1'b0;
        memWriteEn   = 1'b0;
        memByteEn    = '0;
        memWriteData = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_reject)             w_nextState = ST_RESPOND;
                    else if (WAIT_STATES > 0) w_nextState = ST_WAIT;
                    else                      w_nextState = ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (r_waitCnt <= 4'd1) w_nextState = ST_ACCESS;
            end
            ST_ACCESS: begin
                memReadEn   = !r_req.isWrite;
                memWriteEn  = r_req.isWrite;
                if (r_req.isWrite) begin
                    memByteEn    = w_byteEn;
                    memWriteData = w_storeData;
                end
                w_nextState = ST_RESPOND;
            end
            ST_RESPOND: begin
                ready = 1'b1;
                error = r_req.isError;
                if (!r_req.isError && !r_req.isWrite) readData = w_loadData;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    assign memAddress = r_wordAddr;

endmodule

// File: tb/tb_bus_responder.sv
// Randomised bench for bus_responder with a transaction-level reference model,
// plus directed cases and wait-state latency checks on extra instances.
module tb_bus_responder;
    localparam int W = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] address, writeData;
    logic        readReq, writeReq, signedLoad;
    logic [1:0]  size;
    logic        ready, error, memReadEn, memWriteEn;
    logic [31:0] readData, memWriteData, memReadData;
    logic [13:0] memAddress;
    logic [3:0]  memByteEn;

    bus_responder #(.ADDR_WIDTH(14), .WAIT_STATES(W)) dut (
        .clk(clk), .reset(reset), .address(address), .readReq(readReq),
        .writeReq(writeReq), .size(size), .signedLoad(signedLoad),
        .writeData(writeData), .ready(ready), .error(error), .readData(readData),
        .memAddress(memAddress), .memReadEn(memReadEn), .memWriteEn(memWriteEn),
        .memByteEn(memByteEn), .memWriteData(memWriteData), .memReadData(memReadData)
    );

    // Latency instances (0 and 15 wait states) reading a fixed RAM word.
    logic        z_rq = 1'b0, f_rq = 1'b0;
    logic [31:0] c_md = 32'h1234_5678;
    logic        z_ready, z_err, z_ren, z_wen, f_ready, f_err, f_ren, f_wen;
    logic [31:0] z_rd, f_rd, z_unused_wd, f_unused_wd;
    logic [13:0] z_unused_ma, f_unused_ma;
    logic [3:0]  z_unused_be, f_unused_be;

    bus_responder #(.ADDR_WIDTH(14), .WAIT_STATES(0)) dut_w0 (
        .clk(clk), .reset(reset), .address(32'h0), .readReq(z_rq), .writeReq(1'b0),
        .size(2'd2), .signedLoad(1'b0), .writeData(32'h0), .ready(z_ready),
        .error(z_err), .readData(z_rd), .memAddress(z_unused_ma), .memReadEn(z_ren),
        .memWriteEn(z_wen), .memByteEn(z_unused_be), .memWriteData(z_unused_wd),
        .memReadData(c_md)
    );

    bus_responder #(.ADDR_WIDTH(14), .WAIT_STATES(15)) dut_w15 (
        .clk(clk), .reset(reset), .address(32'h0), .readReq(f_rq), .writeReq(1'b0),
        .size(2'd2), .signedLoad(1'b0), .writeData(32'h0), .ready(f_ready),
        .error(f_err), .readData(f_rd), .memAddress(f_unused_ma), .memReadEn(f_ren),
        .memWriteEn(f_wen), .memByteEn(f_unused_be), .memWriteData(f_unused_wd),
        .memReadData(c_md)
    );

    // Bench RAM driven by the DUT strobes; preload port for initial contents.
    logic [31:0] ram [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_a;
    logic [31:0] pl_d;
    always @(posedge clk) begin
        if (pl_en) ram[pl_a] <= pl_d;
        if (memWriteEn)
            for (int b = 0; b < 4; b++)
                if (memByteEn[b]) ram[memAddress][8*b +: 8] <= memWriteData[8*b +: 8];
        if (memReadEn) memReadData <= ram[memAddress];
    end

    // Reference model state: expected RAM contents and the transaction in flight.
    logic [31:0] gold [0:15];
    int          cyc = 0, t0 = 0, total = 0, bad = 0;
    bit          act = 1'b0, mon_on = 1'b0;
    bit          e_err, e_wr, e_sg;
    logic [1:0]  e_sz, e_lane;
    logic [3:0]  e_widx;
    logic [13:0] e_maddr;
    logic [31:0] e_wdraw;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp_v, cyc);
        end
    endtask

    function automatic int lat_of(input bit err);
        return err ? 1 : W + 2;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input bit sg);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (word >> (8 * lane)) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (16 * lane[1])) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_model(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic [31:0] wd);
        logic [31:0] v;
        v = word;
        if (sz == 2'd0)      v[8*lane +: 8]     = wd[7:0];
        else if (sz == 2'd1) v[16*lane[1] +: 16] = wd[15:0];
        else                 v = wd;
        return v;
    endfunction

    function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] lane);
        if (sz == 2'd0) return 4'b0001 << lane;
        if (sz == 2'd1) return lane[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wd_model(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return {4{wd[7:0]}};
        if (sz == 2'd1) return {2{wd[15:0]}};
        return wd;
    endfunction

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        int d, lat;
        bit x_ren, x_wen, x_rdy;
        logic [31:0] x_rd;
        if (mon_on) begin
            d     = cyc - t0;
            lat   = lat_of(e_err);
            x_rdy = act && (d == lat);
            x_ren = act && !e_err && !e_wr && (d == lat - 1);
            x_wen = act && !e_err &&  e_wr && (d == lat - 1);
            x_rd  = 32'h0;
            if (x_rdy && !e_err && !e_wr) x_rd = load_model(gold[e_widx], e_sz, e_lane, e_sg);
            chk("ready",      32'(ready),      32'(x_rdy));
            chk("error",      32'(error),      32'(x_rdy && e_err));
            chk("readData",   readData,        x_rd);
            chk("memReadEn",  32'(memReadEn),  32'(x_ren));
            chk("memWriteEn", 32'(memWriteEn), 32'(x_wen));
            if (x_ren || x_wen) chk("memAddress", 32'(memAddress), 32'(e_maddr));
            if (x_wen) begin
                chk("memByteEn",    32'(memByteEn), 32'(be_model(e_sz, e_lane)));
                chk("memWriteData", memWriteData,   wd_model(e_sz, e_wdraw));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        readReq = rd; writeReq = wr; size = sz; signedLoad = sg; address = a; writeData = wd;
        e_err   = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        e_wr    = wr; e_sz = sz; e_sg = sg; e_lane = a[1:0];
        e_widx  = a[5:2]; e_maddr = a[15:2]; e_wdraw = wd;
        t0      = cyc;
        act     = 1'b1;
    endtask

    task automatic finish_txn();
        if (act && !e_err && e_wr) gold[e_widx] = store_model(gold[e_widx], e_sz, e_lane, e_wdraw);
        act = 1'b0; readReq = 1'b0; writeReq = 1'b0;
    endtask

    task automatic junk();
        readReq  = 1'($urandom_range(0, 1));
        writeReq = 1'($urandom_range(0, 1));
        size     = 2'($urandom_range(0, 3));
        signedLoad = 1'($urandom_range(0, 1));
        address  = $urandom;
        writeData = $urandom;
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        gold[w] = v; pl_a = 14'(w); pl_d = v; pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic lat_test(input bit which);
        int lat;
        lat = which ? 17 : 2;
        tick();
        if (which) f_rq = 1'b1; else z_rq = 1'b1;
        for (int d = 1; d <= 2 * lat + 3; d++) begin
            tick();
            if (d == lat + 2) begin f_rq = 1'b0; z_rq = 1'b0; end
            chk(which ? "ready_w15" : "ready_w0", 32'(which ? f_ready : z_ready),
                32'(d == lat || d == 2 * lat + 1));
            chk(which ? "ren_w15" : "ren_w0", 32'(which ? f_ren : z_ren),
                32'(d == lat - 1 || d == 2 * lat));
            chk(which ? "wen_err_w15" : "wen_err_w0",
                32'(which ? (f_wen | f_err) : (z_wen | z_err)), 32'h0);
            chk(which ? "rdata_w15" : "rdata_w0", which ? f_rd : z_rd,
                (d == lat || d == 2 * lat + 1) ? 32'h1234_5678 : 32'h0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish, limit 40000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit rd, wr, sg;
        logic [1:0] sz, lane;
        logic [3:0] widx;
        reset = 1'b0; readReq = 1'b0; writeReq = 1'b0; size = 2'd0;
        signedLoad = 1'b0; address = 32'h0; writeData = 32'h0;
        for (int i = 0; i < 16; i++)
            preload(i, (i == 0) ? 32'h0080_FF00 : (i == 4) ? 32'hDEAD_BEEF :
                       (i == 8) ? 32'hCAFE_F00D : $urandom);

        // Reset state: every output low.
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_readData", readData, 32'h0);
        chk("rst_strobes", {30'h0, memReadEn, memWriteEn}, 32'h0);
        chk("rst_memAddress", 32'(memAddress), 32'h0);
        chk("rst_memByteEn_wdata", memWriteData | 32'(memByteEn), 32'h0);
        reset = 1'b1;
        mon_on = 1'b1;

        // WORD read at 0x10 of 0xDEADBEEF.
        tick(); start(1, 0, 2'd2, 0, 32'h10, 32'h0);
        tick(); tick();
        chk("d_word_ren", 32'(memReadEn), 32'h1);
        chk("d_word_addr", 32'(memAddress), 32'd4);
        tick();
        chk("d_word_ready", 32'(ready), 32'h1);
        chk("d_word_err", 32'(error), 32'h0);
        chk("d_word_data", readData, 32'hDEAD_BEEF);
        finish_txn();

        // BYTE store of 0xA5 at 0x7.
        tick(); start(0, 1, 2'd0, 0, 32'h7, 32'h0000_00A5);
        tick(); tick();
        chk("d_bst_wen", 32'(memWriteEn), 32'h1);
        chk("d_bst_be", 32'(memByteEn), 32'h8);
        chk("d_bst_wd", memWriteData, 32'hA5A5_A5A5);
        chk("d_bst_addr", 32'(memAddress), 32'd1);
        tick(); finish_txn();

        // Signed and unsigned BYTE loads at 0x2 of 0x0080FF00.
        tick(); start(1, 0, 2'd0, 1, 32'h2, 32'h0);
        tick(); tick(); tick();
        chk("d_lb_signed", readData, 32'hFFFF_FF80);
        finish_txn();
        tick(); start(1, 0, 2'd0, 0, 32'h2, 32'h0);
        tick(); tick(); tick();
        chk("d_lb_unsigned", readData, 32'h0000_0080);
        finish_txn();

        // Rejected requests respond in cycle 1 with no RAM strobe.
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0)      start(1, 0, 2'd1, 0, 32'h3, 32'h0);
            else if (k == 1) start(1, 0, 2'd2, 0, 32'h2, 32'h0);
            else             start(1, 1, 2'd2, 0, 32'h0, 32'h0);
            tick();
            chk("d_err_ready", 32'(ready), 32'h1);
            chk("d_err_error", 32'(error), 32'h1);
            chk("d_err_nostrobe", {30'h0, memReadEn, memWriteEn}, 32'h0);
            finish_txn();
        end

        // Reset during the ACCESS cycle of a WORD store to word 8.
        tick(); start(0, 1, 2'd2, 0, 32'h20, 32'h1111_1111);
        tick(); tick();
        chk("d_rst_wen_before", 32'(memWriteEn), 32'h1);
        act = 1'b0; readReq = 1'b0; writeReq = 1'b0;
        reset = 1'b0;
        #1;
        chk("d_rst_wen_drop", 32'(memWriteEn), 32'h0);
        chk("d_rst_outs_zero", memWriteData | 32'(memByteEn) | 32'(memAddress) | 32'(ready), 32'h0);
        tick();
        reset = 1'b1;
        tick(); tick();
        chk("d_rst_ram_kept", ram[8], 32'hCAFE_F00D);

        // Randomised traffic with junk on the request lines while busy.
        for (int t = 0; t < 250; t++) begin
            tick();
            if ($urandom_range(0, 3) == 0) begin
                readReq = 1'b0; writeReq = 1'b0;
                address = $urandom; size = 2'($urandom_range(0, 3));
                repeat ($urandom_range(1, 2)) tick();
            end
            n  = $urandom_range(0, 15);
            rd = (n == 0) || (n < 8);
            wr = (n == 0) || (n >= 8);
            n  = $urandom_range(0, 9);
            sz = (n < 3) ? 2'd0 : (n < 6) ? 2'd1 : (n < 9) ? 2'd2 : 2'd3;
            lane = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'd1) lane[0] = 1'b0;
                if (sz == 2'd2) lane = 2'd0;
            end
            widx = 4'($urandom_range(0, 15));
            sg   = 1'($urandom_range(0, 1));
            start(rd, wr, sz, sg, ($urandom & 32'hFFFF_0000) | {26'h0, widx, lane}, $urandom);
            n = lat_of(e_err);
            for (int k = 1; k <= n; k++) begin
                tick();
                junk();
            end
            finish_txn();
        end
        tick(); tick();
        for (int i = 0; i < 16; i++) chk("ram_final", ram[i], gold[i]);

        mon_on = 1'b0;
        lat_test(1'b0);
        lat_test(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the CPU's data/instruction bus. It accepts the byte address and access request driven by the CPU address path, inserts a configurable number of wait states, and drives a word-organised synchronous on-chip RAM. It performs byte-lane steering for stores and lane extraction with sign or zero extension for loads, and returns a one-cycle `ready` pulse with the result or an alignment error.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: RAM word-address width; the RAM holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 1: number of wait cycles inserted before each RAM access; range 0–15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  32  byte address from the CPU.
- `readReq`  in  1  load request; sampled only in IDLE.
- `writeReq`  in  1  store request; sampled only in IDLE.
- `size`  in  2  access size: BYTE=0, HALF=1, WORD=2 (3 is illegal).
- `signedLoad`  in  1  1 selects sign extension for BYTE/HALF loads; 0 selects zero extension.
- `writeData`  in  32  store data, right-justified.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `ready`; 1 means the access was rejected.
- `readData`  out  32  aligned load result; valid with `ready` on a successful read, 0 otherwise.
- `memAddress`  out  ADDR_WIDTH  RAM word address, equal to latched `address[ADDR_WIDTH+1:2]`.
- `memReadEn`  out  1  RAM read strobe.
- `memWriteEn`  out  1  RAM write strobe.
- `memByteEn`  out  4  RAM byte-lane write enables.
- `memWriteData`  out  32  lane-replicated store data.
- `memReadData`  in  32  RAM output, valid on the cycle after `memReadEn`.

## Operation
- **States:** IDLE, WAIT, ACCESS, RESPOND.
- **IDLE, `readReq | writeReq` high:**
  - Latch `address`, `size`, `signedLoad`, `writeData` and the request type.
  - Go to ERROR-RESPOND if any of the following holds: `readReq & writeReq`; `size==3`; HALF with `address[0]==1`; WORD with `address[1:0]!=0`.
  - Otherwise go to WAIT if `WAIT_STATES>0`, else go to ACCESS.
- **WAIT:** a down-counter is loaded with `WAIT_STATES` on entry. Move to ACCESS when it reaches 1. The counter is 4 bits wide.
- **ACCESS:** one cycle. Drive `memReadEn` or `memWriteEn` together with `memAddress`, `memByteEn` and `memWriteData`. Then go to RESPOND.
- **RESPOND:** one cycle. `ready=1`. `error` is 1 only when the state was entered from the error path. Then go to IDLE.
- **Requests outside IDLE** are ignored. The requester does not need to hold request inputs after the IDLE sample.
- **Store lanes** (lane = `address[1:0]`):
  - BYTE: data replicated ×4; `memByteEn = 1<<lane`.
  - HALF: data replicated ×2; `memByteEn` = 0011 when `address[1]==0`, 1100 when `address[1]==1`.
  - WORD: `memByteEn` = 1111.
- **Load extraction:** select the byte at lane, or the half at `address[1]`, from `memReadData`, then extend to 32 bits per `signedLoad`. WORD loads pass through unchanged.
- **Address aliasing:** address bits above `ADDR_WIDTH+1` are ignored.
- **Error path:** no RAM strobe is asserted.

## Timing
- **Reset** (asynchronous, any state): return to IDLE immediately. All outputs become 0, including strobes mid-ACCESS; no partial write is issued after reset deasserts.
- **Outputs:** all memory strobes and `ready`/`error`/`readData` decode from registered state and latched fields. No input-to-output combinational path exists except `memReadData` → `readData` during RESPOND.
- **Successful access latency:** request sampled at edge 0; ACCESS occupies cycle `WAIT_STATES+1`; `ready` is high during cycle `WAIT_STATES+2`.
- **Error latency:** `ready`/`error` are high during cycle 1.
- **Minimum request spacing:** `WAIT_STATES+3` cycles, because there is one IDLE cycle after RESPOND.
- **`memReadEn` and `memWriteEn`** are never high together.

## Structure
- **Shared package `busResponderGroup`:**
  - `accessSize` enum (BYTE, HALF, WORD).
  - `responderState` enum.
  - struct of latched request fields.
- **Sub-module `laneAligner`:** combinational; contains the store replication/byte-enable logic and the load extract/extend logic. Unit-testable on its own.
- **Top level:** FSM, wait counter, request latch.

## Test plan
- WAIT_STATES=1: WORD read at 0x10, RAM word 4 = 0xDEADBEEF → `memReadEn` high in cycle 2, `memAddress`=4; `ready=1`, `error=0`, `readData`=0xDEADBEEF in cycle 3.
- BYTE store, address 0x7, `writeData`=0x000000A5 → `memByteEn`=1000, `memWriteData`=0xA5A5A5A5, `memAddress`=1.
- Signed BYTE load at 0x2 with RAM word 0x0080FF00 → `readData`=0xFFFFFF80. The same access unsigned → 0x00000080.
- HALF read at 0x3 → `ready`/`error` high in cycle 1, no RAM strobe. WORD at 0x2 gives the same result. `readReq` and `writeReq` together give the same result.
- `reset` low during ACCESS of a write → `memWriteEn` drops at once; after release the FSM is in IDLE and memory is unchanged. A request during WAIT is ignored.
- WAIT_STATES=0 and WAIT_STATES=15 back-to-back reads → `ready` in cycles 2 and 17; the next request is accepted only in the IDLE cycle after RESPOND.
